// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared core constants and the fetch queue entry type.
package rv_core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo_flush.sv
// sync_fifo_flush: power-of-two circular buffer with push, pop and single-cycle flush.
module sync_fifo_flush #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    // Flush overrides both operations; pointers wrap naturally at the power-of-two depth.
    assign do_push = push_i & ~flush_i;
    assign do_pop = pop_i & ~flush_i;

    always_comb begin
        rd_d = flush_i ? '0 : do_pop ? rd_q + PW'(1) : rd_q;
        wr_d = flush_i ? '0 : do_push ? wr_q + PW'(1) : wr_q;
        cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign dout_o = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the fetch PC, queues fetched instructions for decode,
// and flushes on redirect.
module fetch_queue_unit import rv_core_pkg::*; #(
    parameter logic [31:0] RESET_PC = rv_core_pkg::RESET_VECTOR,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INSN = rv_core_pkg::NOP_INSN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_instr,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     misalign_err
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0] pc_q, pc_d;
    logic mis_q, mis_d;
    logic push, pop;
    fetch_entry_t head, entry;

    assign imem_addr = pc_q;
    assign out_valid = count != '0;
    assign pop = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full queue can still accept a fetch.
    assign push = fetch_en & ~redirect_valid & ((count < CW'(DEPTH)) | pop);
    assign entry = '{pc: pc_q, instr: imem_instr};

    always_comb begin
        pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;
        mis_d = redirect_valid & |redirect_pc[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            mis_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            mis_q <= mis_d;
        end
    end

    sync_fifo_flush #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .din_i   (entry),
        .dout_o  (head),
        .count_o (count)
    );

    assign out_instr = out_valid ? head.instr : NOP_INSN;
    assign out_pc = out_valid ? head.pc : 32'h0;
    assign misalign_err = mis_q;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed plan steps plus random traffic against a queue-based model.
module tb_fetch_queue_unit;
    localparam int D = 4;
    logic clk = 0, rst_n = 0, fetch_en = 0, redirect_valid = 0, out_ready = 0;
    logic [31:0] imem_addr, imem_instr, redirect_pc = 0, out_instr, out_pc;
    logic out_valid, misalign_err;
    logic [2:0] count;
    int total = 0, bad = 0;

    logic [63:0] q[$];
    logic [31:0] m_pc;
    logic m_mis;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h0019_660D) ^ 32'hDEAD_0001;
    endfunction
    assign imem_instr = mem(imem_addr);

    fetch_queue_unit #(.RESET_PC(32'h0), .DEPTH(D), .NOP_INSN(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_instr(imem_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .count(count), .misalign_err(misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("imem_addr", imem_addr, m_pc);
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_instr", out_instr, q.size() != 0 ? q[0][31:0] : 32'h0000_0013);
        chk("out_pc", out_pc, q.size() != 0 ? q[0][63:32] : 32'h0);
        chk("misalign", 32'(misalign_err), 32'(m_mis));
    endtask

    task automatic step(input logic fe, input logic rdy, input logic rv, input logic [31:0] rp);
        fetch_en = fe; out_ready = rdy; redirect_valid = rv; redirect_pc = rp;
        if (rv) begin
            q.delete();
            m_pc = {rp[31:2], 2'b00};
        end else begin
            if (rdy && q.size() != 0) void'(q.pop_front());
            if (fe && q.size() < D) begin
                q.push_back({m_pc, mem(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        m_mis = rv && (rp[1:0] != 2'b00);
        @(posedge clk);
        @(negedge clk);
        chk_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        q.delete();
        m_pc = 32'h0;
        m_mis = 0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0000_0013);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'h0);
        fetch_en = 0; out_ready = 0; redirect_valid = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        do_reset();
        // plan 1: streaming with ready high
        repeat (3) step(1, 1, 0, 0);
        chk("p1_imem", imem_addr, 32'hC);
        chk("p1_out_pc", out_pc, 32'h8);
        chk("p1_count", 32'(count), 32'd1);
        // plan 2: back-pressure until full, then one pop+push
        do_reset();
        repeat (6) step(1, 0, 0, 0);
        chk("p2_count_full", 32'(count), 32'd4);
        chk("p2_imem_hold", imem_addr, 32'h10);
        chk("p2_head", out_instr, mem(32'h0));
        step(1, 1, 0, 0);
        chk("p2_count_pp", 32'(count), 32'd4);
        chk("p2_imem_adv", imem_addr, 32'h14);
        // plan 3: redirect with simultaneous pop
        step(0, 1, 0, 0);
        chk("p3_count3", 32'(count), 32'd3);
        step(1, 1, 1, 32'h100);
        chk("p3_flush_cnt", 32'(count), 32'd0);
        chk("p3_flush_vld", 32'(out_valid), 32'd0);
        chk("p3_flush_nop", out_instr, 32'h0000_0013);
        step(1, 1, 0, 0);
        chk("p3_target", out_pc, 32'h100);
        // plan 4: misaligned redirect
        step(1, 1, 1, 32'h102);
        chk("p4_mis_hi", 32'(misalign_err), 32'd1);
        chk("p4_pc", imem_addr, 32'h100);
        step(1, 1, 0, 0);
        chk("p4_mis_lo", 32'(misalign_err), 32'd0);
        chk("p4_out_pc", out_pc, 32'h100);
        // plan 5: PC wrap
        step(1, 1, 1, 32'hFFFF_FFF8);
        step(1, 1, 0, 0);
        chk("p5_pc0", out_pc, 32'hFFFF_FFF8);
        step(1, 1, 0, 0);
        chk("p5_pc1", out_pc, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        chk("p5_pc2", out_pc, 32'h0);
        // back-to-back redirects, last wins
        step(1, 1, 1, 32'h300);
        step(1, 1, 1, 32'h400);
        step(1, 0, 0, 0);
        chk("b2b_pc", out_pc, 32'h400);
        // plan 6: async reset with two entries queued
        step(1, 0, 1, 32'h200);
        repeat (2) step(1, 0, 0, 0);
        chk("p6_count2", 32'(count), 32'd2);
        do_reset();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rp;
            rp = $urandom;
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, rp);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Upstream neighbour of the instruction memory. Owns the fetch PC and drives the memory's combinational read address. Captures each returned instruction with its PC into a small circular queue and presents entries to decode over a valid/ready handshake. Supports redirect (branch/jump/trap) with a full flush.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC value after reset
DEPTH, 4, queue entries; power of two, minimum 2
NOP_INSN, 32'h0000_0013, value on out_instr when the queue is empty (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  allow new fetches; 0 holds fetch_pc
imem_addr  out  32  address to instruction memory; equals fetch_pc
imem_instr  in  32  combinational read data for imem_addr
redirect_valid  in  1  single-cycle request to change fetch_pc
redirect_pc  in  32  new fetch target
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  32  head instruction; NOP_INSN when empty
out_pc  out  32  head PC; 0 when empty
count  out  $clog2(DEPTH)+1  current occupancy
misalign_err  out  1  one-cycle pulse when redirect_pc[1:0] != 0

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0, out_valid=0, out_instr=NOP_INSN, out_pc=0, misalign_err=0.
- imem_addr = fetch_pc, combinational. imem_instr is sampled in the same cycle.
- push = fetch_en & !redirect_valid & (count<DEPTH | pop). pop = out_valid & out_ready.
- On push: entry {fetch_pc, imem_instr} is written at wr_ptr, wr_ptr increments, and fetch_pc <= fetch_pc+4.
- 32-bit wrap: 0xFFFF_FFFC+4 = 0x0000_0000, no flag.
- Latency: an instruction fetched in cycle N is visible on out_* in cycle N+1. There is no bypass.
- Head outputs are driven combinationally from queue[rd_ptr]. out_valid = (count!=0).
- Pointers wrap modulo DEPTH.
- Count update:
  - push & !pop: count+1
  - pop & !push: count-1
  - push & pop: unchanged. This is legal when full: the entry is freed and refilled in the same cycle.
- Full (count==DEPTH) without pop: no push, and fetch_pc holds.
- Empty: pop is impossible. out_ready is ignored.
- Redirect has priority over everything, including a simultaneous pop:
  - the queue is flushed (rd_ptr=wr_ptr=0, count=0);
  - fetch_pc <= {redirect_pc[31:2],2'b00};
  - no push occurs that cycle;
  - the next cycle fetches the target, and it appears on out_* one cycle after that.
- misalign_err <= redirect_valid & |redirect_pc[1:0], registered, cleared the next cycle.
- Back-to-back redirects: the last one wins. Each redirect flushes.
- fetch_en=0: no push, and fetch_pc holds. Pops and redirects still operate.
- Reset mid-operation: every state register returns to its reset value immediately. Queue contents are don't-care but unobservable, because out_valid=0.
- Queue storage needs no reset. All control state does.

Decomposition:
- Shared package rv_core_pkg:
  - NOP_INSN constant
  - RESET_VECTOR constant
  - XLEN=32
  - fetch_entry_t {pc[31:0], instr[31:0]}
- Sub-module sync_fifo_flush: parameterised DEPTH/WIDTH circular buffer with push, pop, flush, count, and head data.
- The top level holds fetch_pc, push gating, redirect handling, the misalign flag, and the empty-output muxing.

Test Plan:
1. Reset release, fetch_en=1, out_ready=1, memory holds word k at address 4k -> imem_addr steps 0,4,8; out_pc 0,4,8 appears one cycle behind; count stays 1.
2. out_ready=0 for 6 cycles -> count reaches 4; imem_addr holds at 0x10; out_instr stays at the word for PC 0. Raise ready with one pop+push -> count stays 4 and imem_addr becomes 0x14.
3. Queue at 3 entries, redirect_valid with redirect_pc=0x100 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, out_instr=0x00000013; the following cycle out_pc=0x100.
4. redirect_pc=0x102 -> misalign_err=1 for exactly one cycle; fetch resumes at 0x100.
5. Redirect to 0xFFFF_FFF8 with out_ready=1 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. rst_n low mid-stream with count=2 -> out_valid=0, count=0, imem_addr=RESET_PC immediately, without waiting for a clock edge.
